// File: rtl/calc_job_arbiter.sv
// Two-requester round-robin front end for a single shared calculator.
// Optional WAIT timeout with calculator abort is enabled by defining CALC_TIMEOUT_EN.
module calc_job_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [2:0]  mode0,
  input  logic [2:0]  mode1,
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  input  logic [31:0] n0,
  input  logic [31:0] n1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        calc_start,
  output logic [2:0]  calc_mode,
  output logic [31:0] calc_input,
  output logic [31:0] calc_n,
  input  logic        calc_done,
  input  logic [31:0] calc_result,
  output logic        calc_abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3
`ifdef CALC_TIMEOUT_EN
    , ST_ABORT = 3'd4
`endif
  } state_t;

  // A timeout shorter than two cycles would abort before the calculator could ever answer.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("calc_job_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  // Round-robin choice: true when requester 1 should win this cycle.
  function automatic logic rr_pick1(input logic r0, input logic r1, input logic last_gnt);
    logic pick;
    if (r0 && r1) begin
      pick = ~last_gnt;
    end else begin
      pick = r1;
    end
    return pick;
  endfunction

  state_t      state_r;
  logic        last_r;
  logic        id_r;
  logic        calc_start_r;
  logic [2:0]  calc_mode_r;
  logic [31:0] calc_input_r;
  logic [31:0] calc_n_r;
  logic        rsp_valid_r;
  logic        rsp_id_r;
  logic [31:0] rsp_data_r;
  logic        pick1_s;
  logic        gnt0_s;
  logic        gnt1_s;

`ifdef CALC_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_r;
  logic             calc_abort_r;
  logic             rsp_err_r;
`endif

  // Grant decode: only in IDLE and never while reset is asserted.
  always_comb begin
    pick1_s = 1'b0;
    gnt0_s  = 1'b0;
    gnt1_s  = 1'b0;
    if (reset && (state_r == ST_IDLE)) begin
      pick1_s = rr_pick1(req0, req1, last_r);
      gnt0_s  = req0 & ~pick1_s;
      gnt1_s  = req1 & pick1_s;
    end else begin
      pick1_s = 1'b0;
      gnt0_s  = 1'b0;
      gnt1_s  = 1'b0;
    end
  end

  // Job sequencing FSM with all calculator and response outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      last_r       <= 1'b1;
      id_r         <= 1'b0;
      calc_start_r <= 1'b0;
      calc_mode_r  <= 3'd0;
      calc_input_r <= 32'd0;
      calc_n_r     <= 32'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_data_r   <= 32'd0;
`ifdef CALC_TIMEOUT_EN
      tmo_cnt_r    <= '0;
      calc_abort_r <= 1'b0;
      rsp_err_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (gnt0_s || gnt1_s) begin
            id_r         <= gnt1_s;
            last_r       <= gnt1_s;
            calc_mode_r  <= gnt1_s ? mode1 : mode0;
            calc_input_r <= gnt1_s ? x1 : x0;
            calc_n_r     <= gnt1_s ? n1 : n0;
            calc_start_r <= 1'b1;
            state_r      <= ST_ISSUE;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // calc_done is deliberately not looked at here.
          calc_start_r <= 1'b0;
`ifdef CALC_TIMEOUT_EN
          tmo_cnt_r    <= '0;
`endif
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (calc_done) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_data_r  <= calc_result;
`ifdef CALC_TIMEOUT_EN
            rsp_err_r   <= 1'b0;
`endif
            state_r     <= ST_RESP;
          end
`ifdef CALC_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            calc_abort_r <= 1'b1;
            state_r      <= ST_ABORT;
          end else begin
            tmo_cnt_r    <= tmo_cnt_r + 1'b1;
          end
`else
          else begin
            state_r     <= ST_WAIT;
          end
`endif
        end
`ifdef CALC_TIMEOUT_EN
        ST_ABORT: begin
          calc_abort_r <= 1'b0;
          rsp_valid_r  <= 1'b1;
          rsp_id_r     <= id_r;
          rsp_data_r   <= 32'd0;
          rsp_err_r    <= 1'b1;
          state_r      <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r     <= ST_RESP;
          end
        end
        default: begin
          calc_start_r <= 1'b0;
          rsp_valid_r  <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt0       = gnt0_s;
  assign gnt1       = gnt1_s;
  assign calc_start = calc_start_r;
  assign calc_mode  = calc_mode_r;
  assign calc_input = calc_input_r;
  assign calc_n     = calc_n_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_data   = rsp_data_r;
  assign busy       = (state_r != ST_IDLE);

`ifdef CALC_TIMEOUT_EN
  assign calc_abort = calc_abort_r;
  assign rsp_err    = rsp_err_r;
`else
  assign calc_abort = 1'b0;
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_calc_job_arbiter.sv
// Directed bench for calc_job_arbiter: a job-level reference model checked every cycle,
// plus literal latency/ordering expectations. Timeout scenario runs when CALC_TIMEOUT_EN is defined.
module tb_calc_job_arbiter;

  localparam int TMO = 16;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic [2:0]  mode0, mode1;
  logic [31:0] x0, x1, n0, n1;
  logic        gnt0, gnt1;
  logic        calc_start;
  logic [2:0]  calc_mode;
  logic [31:0] calc_input, calc_n;
  logic        calc_done;
  logic [31:0] calc_result;
  logic        calc_abort;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;
  logic        busy;

  calc_job_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .x0(x0), .x1(x1), .n0(n0), .n1(n1),
    .gnt0(gnt0), .gnt1(gnt1),
    .calc_start(calc_start), .calc_mode(calc_mode), .calc_input(calc_input), .calc_n(calc_n),
    .calc_done(calc_done), .calc_result(calc_result), .calc_abort(calc_abort),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Job-level reference model: a job is either absent or in flight; m_age counts cycles since grant.
  bit          m_ok = 1'b0;
  logic        m_active = 1'b0, m_resp = 1'b0, m_abort = 1'b0, m_last = 1'b1;
  logic        m_id = 1'b0, m_err = 1'b0;
  int          m_age = 0;
  logic [2:0]  m_mode = 3'd0;
  logic [31:0] m_x = 32'd0, m_n = 32'd0, m_data = 32'd0;

  function automatic int winner();
    if (req0 && req1) return m_last ? 0 : 1;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_ok <= 1'b1; m_active <= 1'b0; m_resp <= 1'b0; m_abort <= 1'b0; m_last <= 1'b1;
      m_id <= 1'b0; m_err <= 1'b0; m_data <= 32'd0; m_mode <= 3'd0; m_x <= 32'd0;
      m_n <= 32'd0; m_age <= 0;
    end else if (!m_active) begin
      if (winner() >= 0) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_id     <= (winner() == 1);
        m_last   <= (winner() == 1);
        m_mode   <= (winner() == 1) ? mode1 : mode0;
        m_x      <= (winner() == 1) ? x1 : x0;
        m_n      <= (winner() == 1) ? n1 : n0;
      end
    end else begin
      m_age <= m_age + 1;
      if (m_resp) begin
        if (rsp_ready) begin
          m_active <= 1'b0;
          m_resp   <= 1'b0;
        end
      end else if (m_abort) begin
        m_abort <= 1'b0; m_resp <= 1'b1; m_err <= 1'b1; m_data <= 32'd0;
      end else if (m_age >= 2) begin
        if (calc_done) begin
          m_resp <= 1'b1; m_err <= 1'b0; m_data <= calc_result;
        end
`ifdef CALC_TIMEOUT_EN
        else if (m_age - 2 == TMO - 1) begin
          m_abort <= 1'b1;
        end
`endif
      end
    end
  end

  // Single compare process against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk1("gnt0", gnt0, reset && !m_active && (winner() == 0));
      chk1("gnt1", gnt1, reset && !m_active && (winner() == 1));
      chk1("calc_start", calc_start, m_active && (m_age == 1));
      chk1("busy", busy, m_active);
      chk1("rsp_valid", rsp_valid, m_resp);
      chk1("calc_abort", calc_abort, m_abort);
      chk32("calc_mode", {29'd0, calc_mode}, {29'd0, m_mode});
      chk32("calc_input", calc_input, m_x);
      chk32("calc_n", calc_n, m_n);
      if (m_resp) begin
        chk1("rsp_id", rsp_id, m_id);
        chk32("rsp_data", rsp_data, m_data);
        chk1("rsp_err", rsp_err, m_err);
      end
    end
  end

  // Event timestamps used by the literal latency checks.
  int   cyc = 0, gnt_cyc = 0, start_cyc = 0, rsp_cyc = 0, abort_cyc = 0, n_start = 0;
  logic rv_d = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (gnt0 || gnt1) gnt_cyc <= cyc;
    if (calc_start) begin
      start_cyc <= cyc;
      n_start   <= n_start + 1;
    end
    if (rsp_valid && !rv_d) rsp_cyc <= cyc;
    rv_d <= rsp_valid;
    if (calc_abort) abort_cyc <= cyc;
  end

  logic [31:0] last_data;
  logic        last_id, last_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (gnt0 || gnt1) begin
        who = gnt1 ? 1 : 0;
        return;
      end
      tick();
    end
    n_err++;
    $display("FAIL wait_gnt: got no grant expected one within 20 cycles");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "grant timeout");
  endtask

  // One full job: grant, calculator answers lat cycles after calc_start, rsp_ready after rdy cycles.
  task automatic do_job(input int lat, input int rdy, input bit keep, input bit early,
                        input bit raise, input logic [31:0] res, output int who);
    wait_gnt(who);
    tick();
    if (!keep) begin
      if (who == 0) req0 = 1'b0; else req1 = 1'b0;
    end
    if (raise) begin
      if (who == 0) req1 = 1'b1; else req0 = 1'b1;
    end
    if (early) begin
      calc_done   = 1'b1;
      calc_result = 32'hDEADDEAD;
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      calc_done = 1'b0;
    end
    calc_done   = 1'b1;
    calc_result = res;
    tick();
    calc_done = 1'b0;
    last_data = rsp_data;
    last_id   = rsp_id;
    last_err  = rsp_err;
    for (int i = 0; i < rdy; i++) begin
      tick();
      chk1("rsp_hold_valid", rsp_valid, 1'b1);
      chk32("rsp_hold_data", rsp_data, res);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected one before 200000 time units");
    $fatal(1, "watchdog");
  end

  int who;
  int order [4];
  int s0, prev_rsp;

  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; mode0 = 3'd0; mode1 = 3'd0;
    x0 = 32'd0; x1 = 32'd0; n0 = 32'd0; n1 = 32'd0;
    calc_done = 1'b0; calc_result = 32'd0; rsp_ready = 1'b0;
    tick(); tick();
    // Reset values
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_calc_start", calc_start, 1'b0);
    chk32("rst_calc_input", calc_input, 32'd0);
    chk32("rst_rsp_data", rsp_data, 32'd0);
    chk1("rst_calc_abort", calc_abort, 1'b0);
    reset = 1'b1;

    // Contention: both held for four jobs
    mode0 = 3'd2; x0 = 32'h11111111; n0 = 32'd7;
    mode1 = 3'd5; x1 = 32'h22222222; n1 = 32'd9;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_job(2, 0, 1'b1, 1'b0, 1'b0, 32'h000000A0 + 32'(i), who);
      order[i] = who;
      chk32("start_after_gnt", 32'(start_cyc - gnt_cyc), 32'd1);
    end
    req0 = 1'b0; req1 = 1'b0;
    chk32("rr_order0", 32'(order[0]), 32'd0);
    chk32("rr_order1", 32'(order[1]), 32'd1);
    chk32("rr_order2", 32'(order[2]), 32'd0);
    chk32("rr_order3", 32'(order[3]), 32'd1);

    // Single job latency
    mode0 = 3'b001; x0 = 32'h40000000; n0 = 32'd5; req0 = 1'b1;
    s0 = n_start;
    do_job(10, 0, 1'b0, 1'b0, 1'b0, 32'h40800000, who);
    chk32("single_who", 32'(who), 32'd0);
    chk32("single_start_lat", 32'(start_cyc - gnt_cyc), 32'd1);
    chk32("single_start_cnt", 32'(n_start - s0), 32'd1);
    chk32("single_rsp_lat", 32'(rsp_cyc - start_cyc), 32'd11);
    chk32("single_data", last_data, 32'h40800000);
    chk1("single_id", last_id, 1'b0);
    chk1("single_err", last_err, 1'b0);

    // Backpressure on a req1 job, req0 arrives mid-job and must wait
    mode1 = 3'd6; x1 = 32'hCAFE0001; n1 = 32'd3; req1 = 1'b1;
    mode0 = 3'd4; x0 = 32'h0BADF00D; n0 = 32'd12;
    do_job(4, 7, 1'b0, 1'b0, 1'b1, 32'h12345678, who);
    chk32("bp_who", 32'(who), 32'd1);
    chk1("bp_id", last_id, 1'b1);
    #1;
    chk1("gnt0_after_hs", gnt0, 1'b1);
    prev_rsp = rsp_cyc;

    // Early done during ISSUE is ignored; req0 is already pending
    do_job(3, 0, 1'b0, 1'b1, 1'b0, 32'h0000BEEF, who);
    chk32("early_gap", 32'(gnt_cyc - prev_rsp), 32'd8);
    chk32("early_data", last_data, 32'h0000BEEF);
    chk32("early_rsp_lat", 32'(rsp_cyc - start_cyc), 32'd4);

    // Mid-job reset during WAIT of a req0 job
    req0 = 1'b1;
    wait_gnt(who);
    tick();
    req0 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    #1;
    chk1("rst_mid_gnt0", gnt0, 1'b0);
    chk1("rst_mid_gnt1", gnt1, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_mid_calc_n", calc_n, 32'd0);
    reset = 1'b1;
    do_job(1, 0, 1'b0, 1'b0, 1'b0, 32'h00000111, who);
    chk32("rst_first_who", 32'(who), 32'd0);
    do_job(5, 0, 1'b0, 1'b0, 1'b0, 32'h00000222, who);
    chk32("rst_second_who", 32'(who), 32'd1);

`ifdef CALC_TIMEOUT_EN
    // Timeout: calculator never answers
    req1 = 1'b1;
    wait_gnt(who);
    tick();
    req1 = 1'b0;
    for (int i = 0; i < 40 && !calc_abort; i++) tick();
    chk1("tmo_abort_seen", calc_abort, 1'b1);
    tick();
    chk32("tmo_abort_lat", 32'(abort_cyc - start_cyc), 32'd17);
    chk1("tmo_rsp_valid", rsp_valid, 1'b1);
    chk1("tmo_rsp_err", rsp_err, 1'b1);
    chk32("tmo_rsp_data", rsp_data, 32'd0);
    chk1("tmo_rsp_id", rsp_id, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
`endif

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
